// File: rtl/sam_mouse.sv
// -----------------------------------------------------------------------------
// sam_mouse
//
// SAM Coupe mouse interface. Receives the PS/2 mouse byte stream from the MiST
// I/O block, assembles 3-byte movement packets into saturating 12-bit X/Y
// accumulators plus a live button register, and serves the SAM mouse
// nibble-sequence protocol to the ASIC port-254 read mux.
//
// Ports:
//   clk_sys         in   system clock
//   rst_n           in   asynchronous active-low reset
//   ps2_mouse_clk   in   PS/2 clock (asynchronous, synchronised here)
//   ps2_mouse_data  in   PS/2 data  (asynchronous, synchronised here)
//   rd              in   one-cycle pulse at the end of each mouse-port read
//   dout[3:0]       out  current protocol nibble (combinational from index)
//   active          out  high while the sequence index is nonzero
//   pkt_stb         out  one-cycle pulse after a complete packet is accumulated
//
// Build option:
//   PS2_FILTER_EN   when defined, the synchronised PS/2 clock passes through an
//                   8-sample stability filter before edge detection.
// -----------------------------------------------------------------------------
module sam_mouse #(
  parameter int TIMEOUT_CYCLES  = 4800,
  parameter int FRAME_TO_CYCLES = 19200
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       ps2_mouse_clk,
  input  logic       ps2_mouse_data,
  input  logic       rd,
  output logic [3:0] dout,
  output logic       active,
  output logic       pkt_stb
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FT_W = $clog2(FRAME_TO_CYCLES + 1);

  // Overflowed deltas are replaced by the extreme value of their sign.
  function automatic logic signed [8:0] ps2_delta(input logic sgn,
                                                  input logic ovf,
                                                  input logic [7:0] mag);
    if (ovf) return sgn ? 9'sh100 : 9'sh0FF;
    return {sgn, mag};
  endfunction

  // 12-bit + 9-bit signed add, clamped to +2047 / -2048. The 13-bit sum
  // cannot overflow itself, so the top two bits disagreeing flags saturation.
  function automatic logic signed [11:0] sat_add(input logic signed [11:0] acc,
                                                 input logic signed [8:0]  d);
    logic [12:0] s;
    s = {acc[11], acc} + {{4{d[8]}}, d};
    if (s[12] != s[11]) return s[12] ? 12'sh800 : 12'sh7FF;
    return s[11:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic ps2_clk_lvl;

  always_comb begin
    clk_s1_d = ps2_mouse_clk;
    clk_s2_d = clk_s1_q;
    dat_s1_d = ps2_mouse_data;
    dat_s2_d = dat_s1_q;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= clk_s1_d;
      clk_s2_q <= clk_s2_d;
      dat_s1_q <= dat_s1_d;
      dat_s2_q <= dat_s2_d;
    end
  end

`ifdef PS2_FILTER_EN
  // Filtered level only moves after 8 consecutive equal samples.
  logic [7:0] filt_sh_q, filt_sh_d;
  logic       clk_filt_q, clk_filt_d;

  always_comb begin
    filt_sh_d  = {filt_sh_q[6:0], clk_s2_q};
    clk_filt_d = clk_filt_q;
    if (filt_sh_d == 8'hFF)      clk_filt_d = 1'b1;
    else if (filt_sh_d == 8'h00) clk_filt_d = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      filt_sh_q  <= 8'hFF;
      clk_filt_q <= 1'b1;
    end else begin
      filt_sh_q  <= filt_sh_d;
      clk_filt_q <= clk_filt_d;
    end
  end

  assign ps2_clk_lvl = clk_filt_q;
`else
  assign ps2_clk_lvl = clk_s2_q;
`endif

  // ---------------------------------------------------------------------------
  // PS/2 frame receiver
  // ---------------------------------------------------------------------------
  logic            clk_prev_q, clk_prev_d;
  logic            clk_fall, clk_edge;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [FT_W-1:0] ft_cnt_q, ft_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            byte_vld, byte_err;

  assign clk_fall = clk_prev_q & ~ps2_clk_lvl;
  assign clk_edge = clk_prev_q ^ ps2_clk_lvl;

  always_comb begin
    clk_prev_d = ps2_clk_lvl;
    bit_cnt_d  = bit_cnt_q;
    ft_cnt_d   = ft_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    byte_vld   = 1'b0;
    byte_err   = 1'b0;

    if (clk_fall) begin
      if (bit_cnt_q == 4'd0) begin
        // A high start bit is line noise; stay idle.
        if (!dat_s2_q) bit_cnt_d = 4'd1;
      end else if (bit_cnt_q <= 4'd8) begin
        shift_d   = {dat_s2_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == 4'd9) begin
        par_d     = dat_s2_q;
        bit_cnt_d = 4'd10;
      end else begin
        bit_cnt_d = 4'd0;
        if (dat_s2_q && (^{shift_q, par_q})) byte_vld = 1'b1;
        else                                 byte_err = 1'b1;
      end
    end

    // Abandon a partial frame if the clock stalls mid-frame.
    if (bit_cnt_q == 4'd0 || clk_edge) begin
      ft_cnt_d = '0;
    end else if (ft_cnt_q == FT_W'(FRAME_TO_CYCLES - 1)) begin
      ft_cnt_d  = '0;
      bit_cnt_d = 4'd0;
    end else begin
      ft_cnt_d = ft_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet assembly, accumulators and read sequence
  // ---------------------------------------------------------------------------
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [6:0]        hdr_q, hdr_d;      // {yovf, xovf, ysgn, xsgn, mid, right, left}
  logic [7:0]        b1_q, b1_d;
  logic              pkt_done;
  logic signed [8:0] dx, dy;
  logic [2:0]        btn_q, btn_d;
  logic signed [11:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic signed [11:0] acc_x_base, acc_y_base;
  logic [2:0]        snap_btn_q, snap_btn_d;
  logic signed [11:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d;
  logic [3:0]        idx_q, idx_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d, to_cnt_inc;
  logic              active_q, active_d;
  logic              pkt_stb_q, pkt_stb_d;
  logic              rd_snap;

  assign dx = ps2_delta(hdr_q[3], hdr_q[5], b1_q);
  assign dy = ps2_delta(hdr_q[4], hdr_q[6], shift_q);

  always_comb begin
    byte_idx_d = byte_idx_q;
    hdr_d      = hdr_q;
    b1_d       = b1_q;
    pkt_done   = 1'b0;

    if (byte_err) begin
      byte_idx_d = 2'd0;
    end else if (byte_vld) begin
      case (byte_idx_q)
        2'd0: begin
          // Bit 3 is always set in a header byte; use it to resync.
          if (shift_q[3]) begin
            hdr_d      = {shift_q[7:4], shift_q[2:0]};
            byte_idx_d = 2'd1;
          end
        end
        2'd1: begin
          b1_d       = shift_q;
          byte_idx_d = 2'd2;
        end
        default: begin
          byte_idx_d = 2'd0;
          pkt_done   = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    rd_snap    = rd && (idx_q == 4'd0);
    btn_d      = btn_q;
    snap_btn_d = snap_btn_q;
    snap_x_d   = snap_x_q;
    snap_y_d   = snap_y_q;
    idx_d      = idx_q;
    to_cnt_inc = (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) ? to_cnt_q : to_cnt_q + 1'b1;
    to_cnt_d   = to_cnt_inc;
    pkt_stb_d  = pkt_done;

    // A snapshot read clears the accumulators before a same-cycle packet adds.
    acc_x_base = rd_snap ? 12'sd0 : acc_x_q;
    acc_y_base = rd_snap ? 12'sd0 : acc_y_q;
    acc_x_d    = acc_x_base;
    acc_y_d    = acc_y_base;

    if (pkt_done) begin
      acc_x_d = sat_add(acc_x_base, dx);
      acc_y_d = sat_add(acc_y_base, dy);
      btn_d   = hdr_q[2:0];
    end

    if (rd_snap) begin
      snap_btn_d = btn_q;
      snap_x_d   = acc_x_q;
      snap_y_d   = acc_y_q;
    end

    if (rd) begin
      to_cnt_d = '0;
      if (idx_q != 4'd8) idx_d = idx_q + 4'd1;
    end else if (to_cnt_inc == TO_W'(TIMEOUT_CYCLES) && idx_q != 4'd0) begin
      idx_d = 4'd0;
    end

    active_d = (idx_d != 4'd0);
  end

  always_comb begin
    case (idx_q)
      4'd1:    dout = {1'b1, ~snap_btn_q[2], ~snap_btn_q[1], ~snap_btn_q[0]};
      4'd2:    dout = snap_y_q[11:8];
      4'd3:    dout = snap_y_q[7:4];
      4'd4:    dout = snap_y_q[3:0];
      4'd5:    dout = snap_x_q[11:8];
      4'd6:    dout = snap_x_q[7:4];
      4'd7:    dout = snap_x_q[3:0];
      default: dout = 4'hF;
    endcase
  end

  assign active  = active_q;
  assign pkt_stb = pkt_stb_q;

  // Control and architectural state
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_q <= 1'b1;
      bit_cnt_q  <= '0;
      ft_cnt_q   <= '0;
      byte_idx_q <= '0;
      btn_q      <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      snap_btn_q <= '0;
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      idx_q      <= '0;
      to_cnt_q   <= '0;
      active_q   <= 1'b0;
      pkt_stb_q  <= 1'b0;
    end else begin
      clk_prev_q <= clk_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      ft_cnt_q   <= ft_cnt_d;
      byte_idx_q <= byte_idx_d;
      btn_q      <= btn_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      snap_btn_q <= snap_btn_d;
      snap_x_q   <= snap_x_d;
      snap_y_q   <= snap_y_d;
      idx_q      <= idx_d;
      to_cnt_q   <= to_cnt_d;
      active_q   <= active_d;
      pkt_stb_q  <= pkt_stb_d;
    end
  end

  // Byte data holding registers; qualified by the counters above.
  always_ff @(posedge clk_sys) begin
    shift_q <= shift_d;
    par_q   <= par_d;
    hdr_q   <= hdr_d;
    b1_q    <= b1_d;
  end

endmodule

// File: tb/tb_sam_mouse.sv
module tb_sam_mouse;

  localparam int T    = 4800;
  localparam int HALF = 10;
  localparam int GAP  = 10;

  logic       clk_sys;
  logic       rst_n;
  logic       ps2_mouse_clk;
  logic       ps2_mouse_data;
  logic       rd;
  logic [3:0] dout;
  logic       active;
  logic       pkt_stb;

  int n_chk;
  int n_err;
  int stb_cnt;
  int s0;

  sam_mouse #(.TIMEOUT_CYCLES(T), .FRAME_TO_CYCLES(19200)) dut (
    .clk_sys        (clk_sys),
    .rst_n          (rst_n),
    .ps2_mouse_clk  (ps2_mouse_clk),
    .ps2_mouse_data (ps2_mouse_data),
    .rd             (rd),
    .dout           (dout),
    .active         (active),
    .pkt_stb        (pkt_stb)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Counts cycles with pkt_stb high, so a stretched pulse shows up as extra.
  initial stb_cnt = 0;
  always @(negedge clk_sys) if (pkt_stb === 1'b1) stb_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_mouse_data = b;
    repeat (HALF) @(posedge clk_sys);
    ps2_mouse_clk = 1'b0;
    repeat (HALF) @(posedge clk_sys);
    ps2_mouse_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(bad_par ? (^b) : ~(^b));
    ps2_bit(1'b1);
    ps2_mouse_data = 1'b1;
    repeat (GAP) @(posedge clk_sys);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    repeat (5) @(posedge clk_sys);
  endtask

  task automatic rd_nib(input string tag, input logic [3:0] exp);
    @(negedge clk_sys);
    chk(tag, {28'd0, dout}, {28'd0, exp});
    rd = 1'b1;
    @(negedge clk_sys);
    rd = 1'b0;
  endtask

  task automatic rd_seq(input string tag, input logic [35:0] nibs);
    logic [3:0] e;
    for (int i = 0; i < 9; i++) begin
      e = nibs[35 - 4*i -: 4];
      rd_nib($sformatf("%s_n%0d", tag, i), e);
    end
  endtask

  task automatic idle_reset_seq(input string tag);
    repeat (T + 2) @(posedge clk_sys);
    @(negedge clk_sys);
    chk({tag, "_idle_active"}, {31'd0, active}, 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    ps2_mouse_clk = 1'b1;
    ps2_mouse_data = 1'b1;
    rd = 1'b0;
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_dout", {28'd0, dout}, 32'hF);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_stb", {31'd0, pkt_stb}, 32'd0);
    rst_n = 1'b1;

    // Reset mid-sequence and mid-frame
    rd_nib("pre_n0", 4'hF);
    @(negedge clk_sys);
    chk("pre_active", {31'd0, active}, 32'd1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", {28'd0, dout}, 32'hF);
    chk("mid_rst_active", {31'd0, active}, 32'd0);
    ps2_mouse_data = 1'b1;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1'b1;

    // Left button, X=+5, Y=+3
    s0 = stb_cnt;
    send_pkt(8'h09, 8'h05, 8'h03);
    chk("p1_stb", stb_cnt - s0, 32'd1);
    @(negedge clk_sys);
    chk("p1_idle_dout", {28'd0, dout}, 32'hF);
    chk("p1_idle_active", {31'd0, active}, 32'd0);
    rd_seq("p1", 36'hFE003005F);
    rd_nib("p1_n9", 4'hF);
    idle_reset_seq("p1");

    // Negative deltas dx=-2, dy=-1
    send_pkt(8'h38, 8'hFE, 8'hFF);
    rd_seq("p2", 36'hFFFFFFFEF);
    idle_reset_seq("p2");
    rd_seq("p2z", 36'hFF000000F);
    idle_reset_seq("p2z");

    // Bad parity on byte 1 drops the packet; the next one is accepted
    s0 = stb_cnt;
    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (5) @(posedge clk_sys);
    chk("bad_par_stb", stb_cnt - s0, 32'd0);
    send_pkt(8'h0A, 8'h01, 8'h02);
    chk("good_after_bad_stb", stb_cnt - s0, 32'd1);
    rd_seq("p3", 36'hFD002001F);
    idle_reset_seq("p3");

    // Positive saturation: 20 x (+127)
    for (int i = 0; i < 20; i++) send_pkt(8'h08, 8'h7F, 8'h00);
    rd_seq("sat", 36'hFF0007FFF);
    idle_reset_seq("sat");

    // Overflow bits: X -> -256, Y -> +255, nine packets saturate both ways
    for (int i = 0; i < 9; i++) send_pkt(8'hD8, 8'h00, 8'h00);
    rd_seq("ovf", 36'hFF7FF800F);
    idle_reset_seq("ovf");

    // Sequence timeout boundary
    send_pkt(8'h09, 8'h05, 8'h34);
    rd_nib("to_n0", 4'hF);
    rd_nib("to_n1", 4'hE);
    rd_nib("to_n2", 4'h0);
    repeat (T - 1) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("to_hold_active", {31'd0, active}, 32'd1);
    chk("to_hold_dout", {28'd0, dout}, 32'h3);
    rd = 1'b1;
    @(negedge clk_sys);
    rd = 1'b0;
    chk("to_next_dout", {28'd0, dout}, 32'h4);
    repeat (T - 1) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("to_edge_active", {31'd0, active}, 32'd1);
    @(negedge clk_sys);
    chk("to_expired_active", {31'd0, active}, 32'd0);
    chk("to_expired_dout", {28'd0, dout}, 32'hF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
